// File: rtl/sha2_msg_ctrl.sv
// sha2_msg_ctrl: packs a 32-bit big-endian word stream into padded SHA-256
// blocks and sequences an external compression core block by block.
module sha2_msg_ctrl (
  input  logic         clk,
  input  logic         srst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_last_bytes,
  output logic         in_ready,
  output logic         core_srst_n,
  output logic         core_load_en,
  output logic [511:0] core_block,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         busy,
  output logic [255:0] digest,
  output logic         digest_valid
);
  typedef enum logic [2:0] {IDLE, CLR, FILL, PAD, LOAD, WAIT, DONE} state_t;
  state_t        state_q;
  logic [31:0]   buf_q [16];
  logic [3:0]    idx_q;
  logic [31:0]   byte_cnt_q;
  logic [4:0]    pos_q;
  logic          mark_q, last_q, ext_q, ext_ph_q, load_q, dv_q;
  logic [255:0]  digest_q;
  logic [2:0]    n_d;
  logic [31:0]   word_d, len_hi_d, len_lo_d;
  always_comb begin
    n_d = in_last_bytes > 3'd4 ? 3'd4 : in_last_bytes;
    word_d = (in_last && n_d != 3'd4) ?
             (in_data & ~(32'hffffffff >> {n_d, 3'b0})) | (32'h80000000 >> {n_d, 3'b0}) : in_data;
    len_hi_d = {29'b0, byte_cnt_q[31:29]};
    len_lo_d = {byte_cnt_q[28:0], 3'b0};
  end
  assign in_ready     = state_q == FILL;
  assign busy         = !(state_q == IDLE || state_q == DONE);
  assign core_srst_n  = srst_n && state_q != CLR;
  assign core_load_en = load_q;
  assign digest       = digest_q;
  assign digest_valid = dv_q;
  for (genvar g = 0; g < 16; g++) begin : g_blk
    assign core_block[511-32*g -: 32] = buf_q[g];
  end
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
      idx_q <= '0;
      byte_cnt_q <= '0;
      pos_q <= '0;
      mark_q <= 1'b0;
      last_q <= 1'b0;
      ext_q <= 1'b0;
      ext_ph_q <= 1'b0;
      load_q <= 1'b0;
      dv_q <= 1'b0;
      digest_q <= '0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= CLR;
          for (int i = 0; i < 16; i++) buf_q[i] <= '0;
          idx_q <= '0;
          byte_cnt_q <= '0;
          last_q <= 1'b0;
          ext_q <= 1'b0;
          ext_ph_q <= 1'b0;
          dv_q <= 1'b0;
        end
        CLR: state_q <= FILL;
        FILL: if (in_valid) begin
          buf_q[idx_q] <= word_d;
          idx_q <= idx_q + 4'd1;
          byte_cnt_q <= byte_cnt_q + (in_last ? {29'b0, n_d} : 32'd4);
          if (in_last) begin
            state_q <= PAD;
            last_q <= 1'b1;
            mark_q <= n_d == 3'd4;
            pos_q <= {1'b0, idx_q} + (n_d == 3'd4 ? 5'd1 : 5'd0);
          end else if (idx_q == 4'd15) begin
            state_q <= LOAD;
            load_q <= 1'b1;
          end
        end
        // First pass pads the data block; second pass builds the overflow block.
        PAD: begin
          for (int i = 0; i < 16; i++)
            if (ext_ph_q) buf_q[i] <= (i == 0 && pos_q == 5'd16) ? 32'h80000000 : '0;
            else if (5'(i) > pos_q) buf_q[i] <= '0;
            else if (5'(i) == pos_q && mark_q) buf_q[i] <= 32'h80000000;
          if (ext_ph_q || pos_q < 5'd14) begin
            buf_q[14] <= len_hi_d;
            buf_q[15] <= len_lo_d;
          end
          ext_q <= !ext_ph_q && pos_q > 5'd13;
          ext_ph_q <= 1'b0;
          state_q <= LOAD;
          load_q <= 1'b1;
        end
        LOAD: state_q <= WAIT;
        WAIT: if (core_done) begin
          if (!last_q) state_q <= FILL;
          else if (ext_q) begin
            state_q <= PAD;
            ext_ph_q <= 1'b1;
          end else begin
            state_q <= DONE;
            digest_q <= core_digest;
            dv_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
